// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with fetch timeout and retirement counting
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [31:0] imm,
  input  logic        alu_zero,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        inst_load,
  output logic        reg_we,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic [2:0]  state,
  output logic        halt,
  output logic        illegal,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam int TW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(FETCH_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instret_q;
  logic          fault_q;
  logic [TW-1:0] tcnt_q;
  logic          retire;
  logic          timeout;

  logic imem_req_c, dmem_req_c, dmem_we_c, inst_load_c, reg_we_c;
  logic alu_src_c, mem_to_reg_c, halt_c, illegal_c;

  logic is_lw, is_sw;
  assign is_lw = (opcode == OP_LW);
  assign is_sw = (opcode == OP_SW);

  // R-type function field does not influence sequencing
  logic unused_func;
  assign unused_func = ^func;

  // State, pc, retirement counter, sticky fault and fetch wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
      fault_q   <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (retire)  instret_q <= instret_q + 32'd1;
      if (timeout) fault_q   <= 1'b1;
      if (state_q == S_FETCH && !imem_ack) tcnt_q <= tcnt_q + 1'b1;
      else                                 tcnt_q <= '0;
    end
  end

  // Next-state, next-pc and per-state control outputs
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retire       = 1'b0;
    timeout      = 1'b0;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    inst_load_c  = 1'b0;
    reg_we_c     = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    halt_c       = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          inst_load_c = 1'b1;
          state_d     = S_DECODE;
        end else if (tcnt_q == TLIM) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        alu_src_c = (opcode == OP_ADDI) || is_lw || is_sw;
        case (opcode)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ: begin
            pc_d    = alu_zero ? (pc_q + 32'd4 + (imm << 2)) : (pc_q + 32'd4);
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = {pc_q[31:28], imm[25:0], 2'b00};
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            illegal_c = 1'b1;
            pc_d      = pc_q + 32'd4;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_sw;
        if (dmem_ack) begin
          if (is_sw) begin
            pc_d    = pc_q + 32'd4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        mem_to_reg_c = is_lw;
        pc_d         = pc_q + 32'd4;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: halt_c = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every request and pulse output immediately, not just at the next edge
  assign imem_req   = rst_n & imem_req_c;
  assign dmem_req   = rst_n & dmem_req_c;
  assign dmem_we    = rst_n & dmem_we_c;
  assign inst_load  = rst_n & inst_load_c;
  assign reg_we     = rst_n & reg_we_c;
  assign illegal    = rst_n & illegal_c;
  assign halt       = rst_n & halt_c;
  assign alu_src    = alu_src_c;
  assign mem_to_reg = mem_to_reg_c;
  assign pc         = pc_q;
  assign instret    = instret_q;
  assign state      = state_q;
  assign fault      = fault_q;

endmodule
